wheel_pulse_gen: RTL and testbench

Wheel-sensor pulse train generator, the transmitting end of the wheel-speed interface consumed by wheel_speed. It takes a speed setpoint in pulses per measurement window and emits exactly that many evenly spread pulses on `signal` every window. It also emits a window boundary flag. It serves as a hardware odometry stimulus / HIL emulator and drives the same `signal` line that wheel_speed counts.

---
 rtl/wheel_pulse_gen.sv | 135 +++++++++++++
 tb/tb_wheel_pulse_gen.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/wheel_pulse_gen.sv
// Wheel-sensor pulse train generator: emits N evenly spread pulses per window plus a window flag.
// Optional quadrature pair (dir input, sig_b output) enabled by defining WPG_QUAD_EN.
module wheel_pulse_gen #(
  parameter int CNT_W         = 8,
  parameter int WINDOW_CYCLES = 4096,
  parameter int PULSE_W       = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             enable,
  input  logic [CNT_W-1:0] speed_set,
  input  logic             speed_load,
`ifdef WPG_QUAD_EN
  input  logic             dir,
  output logic             sig_b,
`endif
  output logic             signal,
  output logic             window_flag,
  output logic [CNT_W-1:0] pulses_last,
  output logic             overlap_err
);

  localparam int ACC_W = $clog2(WINDOW_CYCLES) + 1;
  localparam int WC_W  = $clog2(WINDOW_CYCLES);
  localparam int PT_W  = $clog2(PULSE_W + 1);
  localparam logic [ACC_W-1:0] W_SIZE = ACC_W'(WINDOW_CYCLES);
  localparam logic [WC_W-1:0]  W_LAST = WC_W'(WINDOW_CYCLES - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_shadow, r_n, r_evcnt, r_pulses_last;
  logic [ACC_W-1:0] r_acc;
  logic [WC_W-1:0]  r_wcnt;
  logic [PT_W-1:0]  r_ptmr;
  logic             r_sig, r_wflag, r_ovl;

  logic             w_run, w_hit, w_busy, w_event, w_last;
  logic [ACC_W-1:0] w_sum;
  logic [PT_W-1:0]  w_ptmr_nxt;

  // Bresenham-style accumulator: a hit whenever acc+N crosses the window length.
  always_comb begin
    w_run   = (r_state == S_RUN) && enable;
    w_sum   = r_acc + ACC_W'(r_n);
    w_hit   = w_run && (w_sum >= W_SIZE);
    w_busy  = (r_ptmr != '0);
    w_event = w_hit && !w_busy;
    w_last  = w_run && (r_wcnt == W_LAST);
    w_ptmr_nxt = '0;
    if (w_event)     w_ptmr_nxt = PT_W'(PULSE_W);
    else if (w_busy) w_ptmr_nxt = r_ptmr - PT_W'(1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state       <= S_IDLE;
      r_shadow      <= '0;
      r_n           <= '0;
      r_evcnt       <= '0;
      r_pulses_last <= '0;
      r_acc         <= '0;
      r_wcnt        <= '0;
      r_ptmr        <= '0;
      r_sig         <= 1'b0;
      r_wflag       <= 1'b0;
      r_ovl         <= 1'b0;
    end else begin
      if (speed_load) r_shadow <= speed_set;
      // Pulse timer keeps running in IDLE so a pulse in flight is never truncated.
      r_ptmr  <= w_ptmr_nxt;
      r_sig   <= (w_ptmr_nxt != '0);
      r_wflag <= w_last;
      if (w_hit && w_busy) r_ovl <= 1'b1;
      case (r_state)
        S_IDLE: begin
          r_wcnt  <= '0;
          r_acc   <= '0;
          r_evcnt <= '0;
          if (enable) begin
            r_state <= S_RUN;
            r_n     <= r_shadow;
          end
        end
        default: begin
          if (!enable) begin
            r_state <= S_IDLE;
            r_wcnt  <= '0;
            r_acc   <= '0;
            r_evcnt <= '0;
          end else begin
            r_acc <= w_hit ? (w_sum - W_SIZE) : w_sum;
            if (w_last) begin
              r_wcnt        <= '0;
              r_pulses_last <= r_evcnt + CNT_W'(w_event);
              r_evcnt       <= '0;
              r_n           <= r_shadow;
            end else begin
              r_wcnt  <= r_wcnt + WC_W'(1);
              r_evcnt <= r_evcnt + CNT_W'(w_event);
            end
          end
        end
      endcase
    end
  end

  assign window_flag = r_wflag;
  assign pulses_last = r_pulses_last;
  assign overlap_err = r_ovl;

`ifdef WPG_QUAD_EN
  localparam int DLY = (PULSE_W / 2 > 1) ? PULSE_W / 2 : 1;

  logic [DLY-1:0] r_dly;
  logic           r_dir_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_dly   <= '0;
      r_dir_q <= 1'b0;
    end else begin
      r_dly[0] <= r_sig;
      for (int i = DLY - 1; i > 0; i--) r_dly[i] <= r_dly[i-1];
      if (w_last || (r_state == S_IDLE && enable)) r_dir_q <= dir;
    end
  end

  assign signal = r_dir_q ? r_dly[DLY-1] : r_sig;
  assign sig_b  = r_dir_q ? r_sig : r_dly[DLY-1];
`else
  assign signal = r_sig;
`endif

endmodule

// File: tb/tb_wheel_pulse_gen.sv
// Directed bench for wheel_pulse_gen (CNT_W=4, WINDOW_CYCLES=64, PULSE_W=2).
module tb_wheel_pulse_gen;
  localparam int CW = 4, WC = 64, PW = 2;

  logic          CLK = 1'b0, RST = 1'b0, enable = 1'b0, speed_load = 1'b0;
  logic [CW-1:0] speed_set = '0;
  logic          signal, window_flag, overlap_err;
  logic [CW-1:0] pulses_last;

  int checks = 0, failures = 0;
  logic [255:0]  wave, flagv;
  logic [CW-1:0] plv [0:255];

  wheel_pulse_gen #(.CNT_W(CW), .WINDOW_CYCLES(WC), .PULSE_W(PW)) dut (
    .CLK(CLK), .RST(RST), .enable(enable), .speed_set(speed_set), .speed_load(speed_load),
    .signal(signal), .window_flag(window_flag), .pulses_last(pulses_last), .overlap_err(overlap_err));

  always #5 CLK = ~CLK;

  // Reference waveform from the even-spread rule: event k iff floor((k+1)N/W) > floor(kN/W).
  function automatic logic [255:0] model(input int n0, input int n1, input int ncyc);
    logic [255:0] e = '0;
    for (int c = 0; c < ncyc; c++) begin
      int k = c % WC;
      int n = (c < WC) ? n0 : n1;
      if (((k + 1) * n) / WC > (k * n) / WC)
        for (int p = 1; p <= PW; p++) if (c + p < 256) e[c+p] = 1'b1;
    end
    return e;
  endfunction

  function automatic int rises(input logic [255:0] w, input int a, input int b);
    int r = 0;
    for (int c = a; c <= b; c++) if (w[c] && !w[c-1]) r++;
    return r;
  endfunction

  // Samples n cycles starting at window cycle 0; optional load / disable actions at given cycles.
  task automatic capture(input int n, input int load_at, input logic [CW-1:0] load_val, input int dis_at);
    wave = '0; flagv = '0;
    for (int c = 0; c < n; c++) begin
      @(negedge CLK);
      wave[c] = signal; flagv[c] = window_flag; plv[c] = pulses_last;
      speed_load = 1'b0;
      if (c == load_at) begin speed_set = load_val; speed_load = 1'b1; end
      if (c == dis_at) enable = 1'b0;
    end
  endtask

  task automatic start(input logic [CW-1:0] n);
    @(negedge CLK); enable = 1'b0; speed_set = n; speed_load = 1'b1;
    @(negedge CLK); speed_load = 1'b0; enable = 1'b1;
  endtask

  task automatic stop();
    @(negedge CLK); enable = 1'b0; speed_load = 1'b0;
    repeat (4) @(negedge CLK);
  endtask

  task automatic cmp_wave(input string name, input logic [255:0] exp, input int n);
    int bad = -1;
    for (int c = n - 1; c >= 0; c--) if (wave[c] !== exp[c]) bad = c;
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL %s: signal at cycle %0d is %b, required %b", name, bad, wave[bad], exp[bad]);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; #3;
    checks += 4;
    if (signal !== 1'b0)       begin failures++; $display("FAIL rst_signal: got %b want 0", signal); end
    if (window_flag !== 1'b0)  begin failures++; $display("FAIL rst_wflag: got %b want 0", window_flag); end
    if (pulses_last !== 4'd0)  begin failures++; $display("FAIL rst_pl: got %0d want 0", pulses_last); end
    if (overlap_err !== 1'b0)  begin failures++; $display("FAIL rst_ovl: got %b want 0", overlap_err); end
    @(negedge CLK); RST = 1'b0;
  endtask

  task automatic test_speed0();
    start(4'd0);
    capture(3 * WC + 1, -1, '0, -1);
    checks += 4;
    if (wave !== '0) begin failures++; $display("FAIL s0_signal: got high count %0d want 0", $countones(wave)); end
    if (flagv !== ((256'd1 << 64) | (256'd1 << 128) | (256'd1 << 192)))
      begin failures++; $display("FAIL s0_wflag: got %0d flags want 3 at 64/128/192", $countones(flagv)); end
    if (plv[192] !== 4'd0)    begin failures++; $display("FAIL s0_pl: got %0d want 0", plv[192]); end
    if (overlap_err !== 1'b0) begin failures++; $display("FAIL s0_ovl: got %b want 0", overlap_err); end
    stop();
  endtask

  task automatic test_speed4();
    logic [255:0] exp;
    start(4'd4);
    capture(WC + 4, -1, '0, -1);
    exp = '0;
    exp[16] = 1; exp[17] = 1; exp[32] = 1; exp[33] = 1;
    exp[48] = 1; exp[49] = 1; exp[64] = 1; exp[65] = 1;
    cmp_wave("s4_wave", exp, WC + 4);
    checks += 3;
    if (plv[64] !== 4'd4)  begin failures++; $display("FAIL s4_pl: got %0d want 4", plv[64]); end
    if (plv[63] !== 4'd0)  begin failures++; $display("FAIL s4_pl_early: got %0d want 0", plv[63]); end
    if (flagv[64] !== 1'b1 || flagv[63] !== 1'b0 || flagv[65] !== 1'b0)
      begin failures++; $display("FAIL s4_wflag: got %b%b%b want 010", flagv[63], flagv[64], flagv[65]); end
    stop();
  endtask

  task automatic test_max_speed();
    start(4'd15);
    capture(WC + 4, -1, '0, -1);
    cmp_wave("s15_wave", model(15, 15, WC + 4), WC + 4);
    checks += 4;
    if (rises(wave, 1, 64) !== 15) begin failures++; $display("FAIL s15_rises: got %0d want 15", rises(wave, 1, 64)); end
    if (wave[4] !== 1'b0 || wave[5] !== 1'b1)
      begin failures++; $display("FAIL s15_first: cycles4/5 got %b%b want 01", wave[4], wave[5]); end
    if (plv[64] !== 4'd15)    begin failures++; $display("FAIL s15_pl: got %0d want 15", plv[64]); end
    if (overlap_err !== 1'b0) begin failures++; $display("FAIL s15_ovl: got %b want 0", overlap_err); end
    stop();
  endtask

  task automatic test_mid_change();
    start(4'd4);
    capture(2 * WC + 3, 20, 4'd8, -1);
    cmp_wave("chg_wave", model(4, 8, 2 * WC + 3), 2 * WC + 3);
    checks += 4;
    if (rises(wave, 1, 64) !== 4)    begin failures++; $display("FAIL chg_r0: got %0d want 4", rises(wave, 1, 64)); end
    if (rises(wave, 65, 128) !== 8)  begin failures++; $display("FAIL chg_r1: got %0d want 8", rises(wave, 65, 128)); end
    if (plv[64] !== 4'd4)  begin failures++; $display("FAIL chg_pl0: got %0d want 4", plv[64]); end
    if (plv[128] !== 4'd8) begin failures++; $display("FAIL chg_pl1: got %0d want 8", plv[128]); end
    stop();
  endtask

  task automatic test_disable_mid_pulse();
    logic [255:0] exp;
    start(4'd4);
    capture(2 * WC + 10, -1, '0, 16);
    exp = '0; exp[16] = 1; exp[17] = 1;
    cmp_wave("dis_wave", exp, 2 * WC + 10);
    checks += 2;
    if (flagv !== '0)   begin failures++; $display("FAIL dis_wflag: got %0d flags want 0", $countones(flagv)); end
    if (plv[2 * WC + 9] !== 4'd8) begin failures++; $display("FAIL dis_pl: got %0d want 8", plv[2 * WC + 9]); end
    stop();
  endtask

  task automatic test_async_rst();
    start(4'd4);
    capture(17, -1, '0, -1);
    checks += 5;
    if (wave[16] !== 1'b1) begin failures++; $display("FAIL ar_pre: signal got %b want 1", wave[16]); end
    #2 RST = 1'b1; #1;
    if (signal !== 1'b0)      begin failures++; $display("FAIL ar_signal: got %b want 0", signal); end
    if (window_flag !== 1'b0) begin failures++; $display("FAIL ar_wflag: got %b want 0", window_flag); end
    if (pulses_last !== 4'd0) begin failures++; $display("FAIL ar_pl: got %0d want 0", pulses_last); end
    @(negedge CLK); RST = 1'b0; enable = 1'b1;
    capture(WC + 10, -1, '0, -1);
    if (wave !== '0) begin failures++; $display("FAIL ar_after: got high count %0d want 0", $countones(wave)); end
    checks += 1;
    if (plv[WC + 9] !== 4'd0) begin failures++; $display("FAIL ar_pl_after: got %0d want 0", plv[WC + 9]); end
    stop();
  endtask

  initial begin
    test_reset();
    test_speed0();
    test_speed4();
    test_max_speed();
    test_mid_change();
    test_disable_mid_pulse();
    test_async_rst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion within 200000 time units");
    $fatal(1);
  end
endmodule
